// File: rtl/blake2_ctrl_pkg.sv
// Shared types and constants for the Blake2 block controller and core arbiter.
// Kept small so both sides agree on state encoding and owner index width.
package blake2_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_DIGEST,
    RELEASE
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 4096;

  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blake2_core_arbiter_rr.sv
// Combinational round-robin pick: first set request after last_owner,
// wrapping modulo NUM_REQ; returns one-hot and binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [OWNER_W-1:0] pick_idx,
  output logic               pick_valid
);

  always_comb begin
    int pos;
    pos         = 0;
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last_owner) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_valid && pos == j && req[j]) begin
          pick_valid     = 1'b1;
          pick_onehot[j] = 1'b1;
          pick_idx       = OWNER_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/blake2_core_arbiter.sv
// Shares one Blake2 core between NUM_REQ controllers, one whole message
// per grant, round-robin; owner strobes are registered to the core.
module blake2_core_arbiter
  import blake2_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BLOCK_WIDTH  = 1024,
  parameter int DATA_LENGTH  = 16,
  parameter int DIGEST_WIDTH = 512,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_init,
  input  logic [NUM_REQ-1:0]             req_next,
  input  logic [NUM_REQ-1:0]             req_final,
  input  logic [NUM_REQ*BLOCK_WIDTH-1:0] req_block,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data_length,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             req_hash_ready,
  output logic [NUM_REQ-1:0]             req_digest_valid,
  output logic [DIGEST_WIDTH-1:0]        digest_out,
  output logic                           busy,
  output logic                           err_protocol,
  output logic                           err_timeout,
  output logic                           init,
  output logic                           next,
  output logic                           final_block,
  output logic [BLOCK_WIDTH-1:0]         block,
  output logic [DATA_LENGTH-1:0]         data_length,
  input  logic                           hash_ready,
  input  logic                           digest_valid,
  input  logic [DIGEST_WIDTH-1:0]        digest
);

  localparam int OWNER_W = owner_w(NUM_REQ);
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  arb_state_t state, state_next;

  logic [OWNER_W-1:0] owner;
  logic [OWNER_W-1:0] last_owner;
  logic               init_sent;
  logic [WD_W-1:0]    wd_cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_valid;

  logic [BLOCK_WIDTH-1:0] blk_arr [NUM_REQ];
  logic [DATA_LENGTH-1:0] len_arr [NUM_REQ];

  logic own_valid;
  logic own_init;
  logic own_next;
  logic own_final;
  logic own_any;
  logic abort;
  logic drop;
  logic fwd;
  logic wd_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_rr (
    .req         (req_valid),
    .last_owner  (last_owner),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      blk_arr[i] = req_block[i*BLOCK_WIDTH +: BLOCK_WIDTH];
      len_arr[i] = req_data_length[i*DATA_LENGTH +: DATA_LENGTH];
    end
  end

  // A message must open with init; dropping req_valid before that aborts.
  always_comb begin
    own_valid = req_valid[owner];
    own_init  = req_init[owner] & hash_ready;
    own_next  = req_next[owner] & hash_ready;
    own_final = req_final[owner] & hash_ready;
    own_any   = own_init | own_next | own_final;
    abort     = !init_sent && !own_valid;
    drop      = !init_sent && own_any && !own_init;
    fwd       = own_any && !drop && !abort;
    wd_hit    = (wd_cnt == WD_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (pick_valid && hash_ready) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (abort)                 state_next = RELEASE;
        else if (fwd && own_final) state_next = WAIT_DIGEST;
      end
      WAIT_DIGEST: begin
        if (digest_valid || wd_hit) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    req_hash_ready = '0;
    if (state == ACTIVE) req_hash_ready = grant & {NUM_REQ{hash_ready}};
    err_timeout = (state == WAIT_DIGEST) && wd_hit && !digest_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant            <= '0;
      owner            <= '0;
      last_owner       <= OWNER_W'(NUM_REQ - 1);
      init_sent        <= 1'b0;
      wd_cnt           <= '0;
      init             <= 1'b0;
      next             <= 1'b0;
      final_block      <= 1'b0;
      block            <= '0;
      data_length      <= '0;
      digest_out       <= '0;
      req_digest_valid <= '0;
      err_protocol     <= 1'b0;
    end else begin
      init             <= 1'b0;
      next             <= 1'b0;
      final_block      <= 1'b0;
      req_digest_valid <= '0;
      err_protocol     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (state_next == ACTIVE) begin
            grant     <= pick_onehot;
            owner     <= pick_idx;
            init_sent <= 1'b0;
          end
        end
        ACTIVE: begin
          if (drop && !abort) begin
            err_protocol <= 1'b1;
          end else if (fwd) begin
            init        <= own_init;
            next        <= own_next;
            final_block <= own_final;
            block       <= blk_arr[owner];
            data_length <= len_arr[owner];
            init_sent   <= 1'b1;
          end
          if (state_next == WAIT_DIGEST) wd_cnt <= '0;
          if (state_next == RELEASE)     grant  <= '0;
        end
        WAIT_DIGEST: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (digest_valid) begin
            digest_out       <= digest;
            req_digest_valid <= grant;
          end
          if (state_next == RELEASE) grant <= '0;
        end
        RELEASE: last_owner <= owner;
        default: grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_core_arbiter.sv
// Scoreboard bench for blake2_core_arbiter: core-side strobes and digest
// pulses are checked against queued expectations, the rest inline per task.
module tb_blake2_core_arbiter;

  localparam int NR  = 4;
  localparam int BW  = 32;
  localparam int DL  = 16;
  localparam int DGW = 64;
  localparam int TO  = 16;
  localparam int CW  = 3 + BW + DL;
  localparam int QW  = NR + DGW;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req_valid, req_init, req_next, req_final;
  logic [BW-1:0] blk [NR];
  logic [DL-1:0] len [NR];
  logic [NR*BW-1:0] req_block;
  logic [NR*DL-1:0] req_data_length;
  logic [NR-1:0] grant, req_hash_ready, req_digest_valid;
  logic [DGW-1:0] digest_out;
  logic busy, err_protocol, err_timeout;
  logic init, next, final_block;
  logic [BW-1:0] block;
  logic [DL-1:0] data_length;
  logic hash_ready, digest_valid;
  logic [DGW-1:0] digest;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] core_q [$];
  logic [QW-1:0] dig_q [$];
  logic [CW-1:0] mon_core;
  logic [QW-1:0] mon_dig;

  localparam logic [DGW-1:0] D1 = 64'hABAB_ABAB_ABAB_ABAB;
  localparam logic [DGW-1:0] D2 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [DGW-1:0] D3 = 64'hCAFE_F00D_0BAD_BEEF;
  localparam logic [DGW-1:0] D4 = 64'h0F0F_1E1E_2D2D_3C3C;
  localparam logic [DGW-1:0] DX = 64'h5555_5555_5555_5555;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_block[g*BW +: BW]       = blk[g];
    assign req_data_length[g*DL +: DL] = len[g];
  end

  blake2_core_arbiter #(
    .NUM_REQ      (NR),
    .BLOCK_WIDTH  (BW),
    .DATA_LENGTH  (DL),
    .DIGEST_WIDTH (DGW),
    .TIMEOUT      (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_init         (req_init),
    .req_next         (req_next),
    .req_final        (req_final),
    .req_block        (req_block),
    .req_data_length  (req_data_length),
    .grant            (grant),
    .req_hash_ready   (req_hash_ready),
    .req_digest_valid (req_digest_valid),
    .digest_out       (digest_out),
    .busy             (busy),
    .err_protocol     (err_protocol),
    .err_timeout      (err_timeout),
    .init             (init),
    .next             (next),
    .final_block      (final_block),
    .block            (block),
    .data_length      (data_length),
    .hash_ready       (hash_ready),
    .digest_valid     (digest_valid),
    .digest           (digest)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (init || next || final_block) begin
        n_checks++;
        if (core_q.size() == 0) begin
          $display("FAIL core_strobe: got ins=%b%b%b blk=%h len=%h, required no strobe",
                   init, next, final_block, block, data_length);
        end else begin
          mon_core = core_q.pop_front();
          if ({init, next, final_block, block, data_length} !== mon_core)
            $display("FAIL core_strobe: got %h, required %h",
                     {init, next, final_block, block, data_length}, mon_core);
          else n_pass++;
        end
      end
      if (|req_digest_valid) begin
        n_checks++;
        if (dig_q.size() == 0) begin
          $display("FAIL digest_pulse: got %b, required no pulse", req_digest_valid);
        end else begin
          mon_dig = dig_q.pop_front();
          if ({req_digest_valid, digest_out} !== mon_dig)
            $display("FAIL digest_pulse: got %h, required %h",
                     {req_digest_valid, digest_out}, mon_dig);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] r, input logic i, input logic n,
                        input logic f, input logic [BW-1:0] b,
                        input logic [DL-1:0] l, input bit fwd);
    req_init[r]  = i;
    req_next[r]  = n;
    req_final[r] = f;
    blk[r]       = b;
    len[r]       = l;
    if (fwd) core_q.push_back({i, n, f, b, l});
  endtask

  task automatic clr();
    req_init  = '0;
    req_next  = '0;
    req_final = '0;
  endtask

  task automatic pulse_digest(input logic [DGW-1:0] d, input logic [NR-1:0] who);
    digest       = d;
    digest_valid = 1'b1;
    dig_q.push_back({who, d});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    clr();
    for (int i = 0; i < NR; i++) begin
      blk[i] = '0;
      len[i] = '0;
    end
    hash_ready   = 1'b0;
    digest_valid = 1'b0;
    digest       = '0;
    #12;
    n_checks++;
    if ({grant, req_hash_ready, req_digest_valid, busy, err_protocol, err_timeout} !== '0)
      $display("FAIL reset_ctrl: got %h, required 0",
               {grant, req_hash_ready, req_digest_valid, busy, err_protocol, err_timeout});
    else n_pass++;
    n_checks++;
    if ({init, next, final_block, block, data_length, digest_out} !== '0)
      $display("FAIL reset_core: got %h, required 0",
               {init, next, final_block, block, data_length, digest_out});
    else n_pass++;
    tick();
    reset = 1'b0;
    req_valid = 4'b0001;
    tick();
    tick();
    n_checks++;
    if ({grant, busy} !== 5'b0)
      $display("FAIL no_ready_grant: got %b, required 00000", {grant, busy});
    else n_pass++;
  endtask

  task automatic test_single_block();
    hash_ready = 1'b1;
    tick();
    n_checks++;
    if ({grant, req_hash_ready, busy} !== 9'b0001_0001_1)
      $display("FAIL t1_grant: got %b, required 000100011", {grant, req_hash_ready, busy});
    else n_pass++;
    strobe(2'd0, 1'b1, 1'b0, 1'b1, 32'h1111_0001, 16'd64, 1'b1);
    tick();
    clr();
    n_checks++;
    if ({init, next, final_block, req_hash_ready} !== 7'b101_0000)
      $display("FAIL t1_core: got %b, required 1010000",
               {init, next, final_block, req_hash_ready});
    else n_pass++;
    pulse_digest(D1, 4'b0001);
    tick();
    digest_valid = 1'b0;
    req_valid    = '0;
    n_checks++;
    if ({req_digest_valid, grant, digest_out} !== {4'b0001, 4'b0000, D1})
      $display("FAIL t1_digest: got %b %b %h, required 0001 0000 %h",
               req_digest_valid, grant, digest_out, D1);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy, req_digest_valid} !== 5'b0)
      $display("FAIL t1_idle: got %b, required 00000", {busy, req_digest_valid});
    else n_pass++;
  endtask

  task automatic test_round_robin();
    req_valid = 4'b0110;
    tick();
    n_checks++;
    if (grant !== 4'b0010)
      $display("FAIL t2_first: got %b, required 0010", grant);
    else n_pass++;
    strobe(2'd1, 1'b1, 1'b0, 1'b1, 32'h2222_0001, 16'd8, 1'b1);
    tick();
    clr();
    pulse_digest(D2, 4'b0010);
    req_valid = 4'b0100;
    tick();
    digest_valid = 1'b0;
    n_checks++;
    if (grant !== 4'b0000)
      $display("FAIL t2_release: got %b, required 0000", grant);
    else n_pass++;
    tick();
    n_checks++;
    if (grant !== 4'b0000)
      $display("FAIL t2_gap: got %b, required 0000", grant);
    else n_pass++;
    tick();
    n_checks++;
    if (grant !== 4'b0100)
      $display("FAIL t2_second: got %b, required 0100", grant);
    else n_pass++;
    strobe(2'd2, 1'b1, 1'b0, 1'b1, 32'h3333_0001, 16'd16, 1'b1);
    tick();
    clr();
    pulse_digest(D2 ^ D1, 4'b0100);
    req_valid = '0;
    tick();
    digest_valid = 1'b0;
    tick();
  endtask

  task automatic test_multi_block();
    req_valid = 4'b1001;
    tick();
    n_checks++;
    if (grant !== 4'b1000)
      $display("FAIL t3_grant: got %b, required 1000", grant);
    else n_pass++;
    strobe(2'd3, 1'b1, 1'b0, 1'b0, 32'h4444_0001, 16'd128, 1'b1);
    strobe(2'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000, 16'd1, 1'b0);
    tick();
    clr();
    hash_ready = 1'b0;
    strobe(2'd3, 1'b0, 1'b1, 1'b0, 32'h4444_00FF, 16'd256, 1'b0);
    #1;
    n_checks++;
    if (req_hash_ready !== 4'b0000)
      $display("FAIL t3_ready_gate: got %b, required 0000", req_hash_ready);
    else n_pass++;
    tick();
    clr();
    hash_ready = 1'b1;
    strobe(2'd3, 1'b0, 1'b1, 1'b0, 32'h4444_0002, 16'd256, 1'b1);
    strobe(2'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD_0001, 16'd2, 1'b0);
    tick();
    clr();
    strobe(2'd3, 1'b0, 1'b0, 1'b1, 32'h4444_0003, 16'd300, 1'b1);
    strobe(2'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0002, 16'd3, 1'b0);
    tick();
    clr();
    n_checks++;
    if ({grant, req_hash_ready} !== 8'b1000_0000)
      $display("FAIL t3_wait: got %b, required 10000000", {grant, req_hash_ready});
    else n_pass++;
    pulse_digest(D3, 4'b1000);
    tick();
    digest_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (grant !== 4'b0001)
      $display("FAIL t3_next_owner: got %b, required 0001", grant);
    else n_pass++;
  endtask

  task automatic test_protocol_error();
    strobe(2'd0, 1'b0, 1'b1, 1'b0, 32'hBAD0_0001, 16'd5, 1'b0);
    tick();
    clr();
    n_checks++;
    if ({err_protocol, init, next, final_block, grant, busy} !== 9'b1000_0001_1)
      $display("FAIL t4_err: got %b, required 100000011",
               {err_protocol, init, next, final_block, grant, busy});
    else n_pass++;
    tick();
    n_checks++;
    if ({err_protocol, busy, grant} !== 6'b0_1_0001)
      $display("FAIL t4_pulse: got %b, required 010001", {err_protocol, busy, grant});
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    strobe(2'd0, 1'b1, 1'b0, 1'b1, 32'h5555_0001, 16'd32, 1'b1);
    tick();
    clr();
    req_valid = '0;
    for (int k = 1; k <= TO - 1; k++) begin
      if (err_timeout !== 1'b0 || grant !== 4'b0001) early = 1'b1;
      tick();
    end
    n_checks++;
    if (early)
      $display("FAIL t5_early: got early timeout/release, required none before cycle %0d", TO);
    else n_pass++;
    n_checks++;
    if ({err_timeout, grant} !== 5'b1_0001)
      $display("FAIL t5_fire: got %b, required 10001", {err_timeout, grant});
    else n_pass++;
    tick();
    n_checks++;
    if ({err_timeout, grant, busy} !== 6'b0_0000_1)
      $display("FAIL t5_release: got %b, required 000001", {err_timeout, grant, busy});
    else n_pass++;
    digest       = DX;
    digest_valid = 1'b1;
    tick();
    digest_valid = 1'b0;
    n_checks++;
    if ({req_digest_valid, digest_out} !== {4'b0000, D3})
      $display("FAIL t5_stray_digest: got %b %h, required 0000 %h",
               req_digest_valid, digest_out, D3);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0011;
    tick();
    n_checks++;
    if (grant !== 4'b0010)
      $display("FAIL t6_grant: got %b, required 0010", grant);
    else n_pass++;
    strobe(2'd1, 1'b1, 1'b0, 1'b1, 32'h6666_0001, 16'd48, 1'b1);
    tick();
    clr();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, busy, req_hash_ready, init, next, final_block, block, data_length, digest_out}
        !== '0)
      $display("FAIL t6_async: got %h, required 0",
               {grant, busy, req_hash_ready, init, next, final_block, block,
                data_length, digest_out});
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0001)
      $display("FAIL t6_after_reset: got %b, required 0001", grant);
    else n_pass++;
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_round_robin();
    test_multi_block();
    test_protocol_error();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (core_q.size() != 0 || dig_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d core %0d digest left, required 0 0",
               core_q.size(), dig_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
